cpu_ctrl: RTL and testbench

Multicycle control sequencer for the 8-bit CPU. It fetches 16-bit instructions over a req/ack port, decodes them, and drives the register-file read/write addresses, write enable and ALU opcode. It also owns the program counter, jumps, branches and halt. It sits between instruction memory and the `reg_file`/ALU datapath; `reg_file` is unchanged.

---
 rtl/cpu_pkg.sv | 46 ++++
 rtl/cpu_decode.sv | 75 +++++++
 rtl/cpu_ctrl.sv | 122 ++++++++++++
 tb/tb_cpu_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the 8-bit CPU control path.
// Instruction word: opcode[15:12], rd[11:8], rs1[7:4], rs2[3:0], imm8/target[7:0].
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_MOV  = 4'h7,
    OP_JMP  = 4'h8,
    OP_BEQZ = 4'h9,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD    = 3'd0,
    ALU_SUB    = 3'd1,
    ALU_AND    = 3'd2,
    ALU_OR     = 3'd3,
    ALU_XOR    = 3'd4,
    ALU_PASS_B = 3'd5
  } alu_op_e;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_HALT    = 3'd3,
    S_STEP    = 3'd4
  } state_e;

  localparam int OPC_LSB = 12;
  localparam int RD_LSB  = 8;
  localparam int RS1_LSB = 4;
  localparam int RS2_LSB = 0;
  localparam int FIELD_W = 4;
  localparam int IMM_W   = 8;

  localparam logic [3:0] REG_ZERO = 4'd0;
  localparam logic [3:0] REG_OUT  = 4'd15;

endpackage

// File: rtl/cpu_decode.sv
// Combinational instruction decode: IR -> register addresses, ALU control and flow flags.
// Unused address fields are driven to zero so idle instructions present quiet buses.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [15:0] i_ir,
  output logic [3:0]  o_ra1,
  output logic [3:0]  o_ra2,
  output logic [3:0]  o_wa,
  output logic [2:0]  o_alu_op,
  output logic        o_imm_sel,
  output logic        o_writes_rd,
  output logic        o_is_jmp,
  output logic        o_is_beqz,
  output logic        o_is_halt
);

  opcode_e    w_opc;
  logic [3:0] w_rd;
  logic [3:0] w_rs1;
  logic [3:0] w_rs2;

  assign w_opc = opcode_e'(i_ir[OPC_LSB +: FIELD_W]);
  assign w_rd  = i_ir[RD_LSB  +: FIELD_W];
  assign w_rs1 = i_ir[RS1_LSB +: FIELD_W];
  assign w_rs2 = i_ir[RS2_LSB +: FIELD_W];

  always_comb begin
    o_ra1       = REG_ZERO;
    o_ra2       = REG_ZERO;
    o_wa        = REG_ZERO;
    o_alu_op    = ALU_ADD;
    o_imm_sel   = 1'b0;
    o_writes_rd = 1'b0;
    o_is_jmp    = 1'b0;
    o_is_beqz   = 1'b0;
    o_is_halt   = 1'b0;
    case (w_opc)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        o_ra1       = w_rs1;
        o_ra2       = w_rs2;
        o_wa        = w_rd;
        o_writes_rd = 1'b1;
      end
      OP_LDI: begin
        o_wa        = w_rd;
        o_imm_sel   = 1'b1;
        o_writes_rd = 1'b1;
      end
      OP_MOV: begin
        o_ra2       = w_rs2;
        o_wa        = w_rd;
        o_writes_rd = 1'b1;
      end
      OP_JMP:  o_is_jmp = 1'b1;
      // Branch tests the rd register, so it goes out on read port 1.
      OP_BEQZ: begin
        o_ra1     = w_rd;
        o_is_beqz = 1'b1;
      end
      OP_HALT: o_is_halt = 1'b1;
      default: ;
    endcase

    case (w_opc)
      OP_SUB:         o_alu_op = ALU_SUB;
      OP_AND:         o_alu_op = ALU_AND;
      OP_OR:          o_alu_op = ALU_OR;
      OP_XOR:         o_alu_op = ALU_XOR;
      OP_LDI, OP_MOV: o_alu_op = ALU_PASS_B;
      default:        o_alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Multicycle fetch/decode/execute sequencer owning PC, IR, jumps, branches and halt.
// Optional single-step mode is enabled with `define CPU_CTRL_STEP_EN (adds the step input).
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter logic [7:0] START_ADDR = 8'h00
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [7:0]  imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  RA1,
  output logic [3:0]  RA2,
  output logic [3:0]  WA,
  output logic        write_enable,
  output logic [2:0]  alu_op,
  output logic        imm_sel,
  output logic [7:0]  imm,
  input  logic [7:0]  RD1,
  output logic        halted
`ifdef CPU_CTRL_STEP_EN
  ,
  input  logic        step
`endif
);

`ifdef CPU_CTRL_STEP_EN
  localparam state_e S_ENTRY = S_STEP;
`else
  localparam state_e S_ENTRY = S_FETCH;
`endif

  state_e      r_state;
  state_e      w_state_nxt;
  logic [7:0]  r_pc;
  logic [15:0] r_ir;

  logic [3:0]  w_ra1;
  logic [3:0]  w_ra2;
  logic [3:0]  w_wa;
  logic [2:0]  w_alu_op;
  logic        w_imm_sel;
  logic        w_writes_rd;
  logic        w_is_jmp;
  logic        w_is_beqz;
  logic        w_is_halt;
  logic        w_ctl_active;
  logic        w_fetch_done;
  logic        w_branch;

  cpu_decode u_decode (
    .i_ir        (r_ir),
    .o_ra1       (w_ra1),
    .o_ra2       (w_ra2),
    .o_wa        (w_wa),
    .o_alu_op    (w_alu_op),
    .o_imm_sel   (w_imm_sel),
    .o_writes_rd (w_writes_rd),
    .o_is_jmp    (w_is_jmp),
    .o_is_beqz   (w_is_beqz),
    .o_is_halt   (w_is_halt)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_ENTRY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
`ifdef CPU_CTRL_STEP_EN
      S_STEP:    if (step) w_state_nxt = S_FETCH;
`else
      S_STEP:    w_state_nxt = S_FETCH;
`endif
      S_FETCH:   if (imem_ack) w_state_nxt = S_DECODE;
      S_DECODE:  w_state_nxt = S_EXECUTE;
      S_EXECUTE: w_state_nxt = w_is_halt ? S_HALT : S_ENTRY;
      S_HALT:    w_state_nxt = S_HALT;
      default:   w_state_nxt = S_ENTRY;
    endcase
  end

  // Ack only counts while a request is out, which is exactly the FETCH state.
  assign w_fetch_done = (r_state == S_FETCH) && imem_ack;
  assign w_branch     = (r_state == S_EXECUTE) &&
                        (w_is_jmp || (w_is_beqz && (RD1 == 8'h00)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= START_ADDR;
      r_ir <= 16'h0000;
    end else begin
      if (w_fetch_done) begin
        r_ir <= imem_data;
        r_pc <= r_pc + 8'd1;
      end else if (w_branch) begin
        r_pc <= r_ir[IMM_W-1:0];
      end
    end
  end

  // Decode outputs are only presented while the instruction is in flight, so they
  // read as zero in FETCH/HALT and after an asynchronous reset.
  assign w_ctl_active = (r_state == S_DECODE) || (r_state == S_EXECUTE);

  assign RA1     = w_ctl_active ? w_ra1     : REG_ZERO;
  assign RA2     = w_ctl_active ? w_ra2     : REG_ZERO;
  assign WA      = w_ctl_active ? w_wa      : REG_ZERO;
  assign alu_op  = w_ctl_active ? w_alu_op  : ALU_ADD;
  assign imm_sel = w_ctl_active ? w_imm_sel : 1'b0;
  assign imm     = r_ir[IMM_W-1:0];

  assign write_enable = !reset && (r_state == S_EXECUTE) && w_writes_rd && (w_wa != REG_ZERO);
  assign imem_req     = !reset && (r_state == S_FETCH);
  assign imem_addr    = r_pc;
  assign halted       = (r_state == S_HALT);

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed test of cpu_ctrl with START_ADDR=8'h10: fetch timing, writes, branches, PC wrap, halt, async reset.
module tb_cpu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_data;
  logic [3:0]  RA1, RA2, WA;
  logic        write_enable;
  logic [2:0]  alu_op;
  logic        imm_sel;
  logic [7:0]  imm;
  logic [7:0]  RD1;
  logic        halted;

  int vectors = 0;
  int miscompares = 0;

  logic [15:0] dec_bus;
  assign dec_bus = {RA1, RA2, WA, alu_op, imm_sel};

  cpu_ctrl #(.START_ADDR(8'h10)) dut (
    .clk          (clk),
    .reset        (reset),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_data    (imem_data),
    .RA1          (RA1),
    .RA2          (RA2),
    .WA           (WA),
    .write_enable (write_enable),
    .alu_op       (alu_op),
    .imm_sel      (imm_sel),
    .imm          (imm),
    .RD1          (RD1),
    .halted       (halted)
`ifdef CPU_CTRL_STEP_EN
    ,
    .step         (1'b1)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Present one instruction with zero-wait ack; returns at the DECODE-cycle negedge.
  task automatic go(input logic [15:0] d);
    imem_ack  = 1'b1;
    imem_data = d;
    @(negedge clk);
    imem_ack  = 1'b0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; imem_data = 16'h0000; RD1 = 8'h00;
    repeat (2) cyc();
    chk("rst_req",    {15'd0, imem_req},     16'h0000);
    chk("rst_addr",   {8'd0, imem_addr},     16'h0010);
    chk("rst_we",     {15'd0, write_enable}, 16'h0000);
    chk("rst_halted", {15'd0, halted},       16'h0000);
    chk("rst_dec",    dec_bus,               16'h0000);
    reset = 1'b0;
    #1;
    chk("rel_req",  {15'd0, imem_req}, 16'h0001);
    chk("rel_addr", {8'd0, imem_addr}, 16'h0010);
    chk("rel_dec",  dec_bus,           16'h0000);
    chk("rel_imm",  {8'd0, imm},       16'h0000);

    // LDI r3,0x2A
    go(16'h632A);
    chk("ldi_dec_bus", dec_bus,               16'h003B);
    chk("ldi_dec_we",  {15'd0, write_enable}, 16'h0000);
    chk("ldi_dec_req", {15'd0, imem_req},     16'h0000);
    cyc();
    chk("ldi_ex_we",   {15'd0, write_enable}, 16'h0001);
    chk("ldi_ex_bus",  dec_bus,               16'h003B);
    chk("ldi_ex_imm",  {8'd0, imm},           16'h002A);
    cyc();
    chk("ldi_nx_we",   {15'd0, write_enable}, 16'h0000);
    chk("ldi_nx_req",  {15'd0, imem_req},     16'h0001);
    chk("ldi_nx_addr", {8'd0, imem_addr},     16'h0011);

    // ADD r0,r1,r2: write to r0 suppressed
    go(16'h1012);
    chk("add0_dec_bus", dec_bus,               16'h1200);
    chk("add0_dec_we",  {15'd0, write_enable}, 16'h0000);
    cyc();
    chk("add0_ex_we",   {15'd0, write_enable}, 16'h0000);
    cyc();
    chk("add0_nx_addr", {8'd0, imem_addr},     16'h0012);

    // BEQZ r4,0x40 taken
    go(16'h9440);
    chk("beqz_dec_ra1", dec_bus, 16'h4000);
    RD1 = 8'h00;
    cyc();
    chk("beqz_ex_we", {15'd0, write_enable}, 16'h0000);
    cyc();
    chk("beqz_t_addr", {8'd0, imem_addr}, 16'h0040);

    // BEQZ r4,0x40 not taken
    go(16'h9440);
    RD1 = 8'h01;
    cyc(); cyc();
    chk("beqz_nt_addr", {8'd0, imem_addr}, 16'h0041);
    RD1 = 8'h00;

    // JMP 0xFF, then hold off ack for three cycles
    go(16'h80FF);
    cyc(); cyc();
    chk("jmp_addr", {8'd0, imem_addr}, 16'h00FF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("wait_req",  {15'd0, imem_req}, 16'h0001);
      chk("wait_addr", {8'd0, imem_addr}, 16'h00FF);
    end

    // NOP at 0xFF: PC wraps
    go(16'h0000);
    chk("nop_dec_bus", dec_bus, 16'h0000);
    cyc();
    chk("nop_ex_we", {15'd0, write_enable}, 16'h0000);
    cyc();
    chk("wrap_addr", {8'd0, imem_addr}, 16'h0000);

    // MOV r5,r3
    go(16'h7503);
    chk("mov_dec_bus", dec_bus, 16'h035A);
    cyc();
    chk("mov_ex_we", {15'd0, write_enable}, 16'h0001);
    cyc();
    chk("mov_nx_addr", {8'd0, imem_addr}, 16'h0001);

    // SUB r2,r3,r4
    go(16'h2234);
    cyc();
    chk("sub_ex_bus", dec_bus,               16'h3422);
    chk("sub_ex_we",  {15'd0, write_enable}, 16'h0001);
    cyc();

    // HALT, with stray acks that must be ignored
    go(16'hF000);
    cyc();
    chk("halt_ex_halted", {15'd0, halted}, 16'h0000);
    cyc();
    chk("halt_halted", {15'd0, halted},   16'h0001);
    chk("halt_req",    {15'd0, imem_req}, 16'h0000);
    imem_ack = 1'b1; imem_data = 16'h632A;
    repeat (3) cyc();
    chk("halt_stay",      {15'd0, halted},       16'h0001);
    chk("halt_stay_req",  {15'd0, imem_req},     16'h0000);
    chk("halt_stay_we",   {15'd0, write_enable}, 16'h0000);
    chk("halt_stay_addr", {8'd0, imem_addr},     16'h0003);
    imem_ack = 1'b0;

    reset = 1'b1;
    cyc();
    reset = 1'b0;
    #1;
    chk("rerun_halted", {15'd0, halted},   16'h0000);
    chk("rerun_req",    {15'd0, imem_req}, 16'h0001);
    chk("rerun_addr",   {8'd0, imem_addr}, 16'h0010);

    // Reset asserted mid-DECODE
    go(16'h632A);
    chk("mid_dec_bus", dec_bus, 16'h003B);
    reset = 1'b1;
    #1;
    chk("arst_dec_bus", dec_bus,           16'h0000);
    chk("arst_dec_req", {15'd0, imem_req}, 16'h0000);
    chk("arst_addr",    {8'd0, imem_addr}, 16'h0010);
    chk("arst_imm",     {8'd0, imm},       16'h0000);
    cyc();
    reset = 1'b0;
    #1;

    // XOR r7,r1,r2 then reset during EXECUTE
    go(16'h5712);
    cyc();
    chk("xor_ex_bus", dec_bus,               16'h1278);
    chk("xor_ex_we",  {15'd0, write_enable}, 16'h0001);
    reset = 1'b1;
    #1;
    chk("arst_ex_we",  {15'd0, write_enable}, 16'h0000);
    chk("arst_ex_req", {15'd0, imem_req},     16'h0000);
    cyc();
    reset = 1'b0;
    #1;
    chk("final_req",  {15'd0, imem_req}, 16'h0001);
    chk("final_addr", {8'd0, imem_addr}, 16'h0010);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
